// File: rtl/ring_buff_loop_reader.sv
// ============================================================================
// Module   : ring_buff_loop_reader
// Function : Read-side sequencer for the ring buffer with hardware loop replay
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ring_buff_loop_reader #(
  parameter int NUM_ENTRY = 16,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 8,
  localparam int AW       = $clog2(NUM_ENTRY)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              I_Enable,
  input  logic              I_Empty,
  input  logic [AW-1:0]     I_RAddr,
  input  logic [DATA_W-1:0] I_RData,
  output logic              O_Re,
  output logic              O_Update,
  output logic [AW-1:0]     O_UpdateLen,
  input  logic              I_LoopReq,
  input  logic [AW-1:0]     I_LoopLen,
  input  logic [CNT_W-1:0]  I_LoopCnt,
  output logic              O_LoopAck,
  output logic              O_LoopDone,
  output logic              O_Busy,
  output logic              O_Valid,
  output logic [DATA_W-1:0] O_Data,
  input  logic              I_Ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOOP = 2'd2
  } state_t;

  state_t           state;
  logic [AW-1:0]    body_len;
  logic [AW-1:0]    body_idx;
  logic [CNT_W-1:0] iter_left;

  logic slot_free;
  logic issue;
  logic body_end;

  assign slot_free = ~O_Valid | I_Ready;
  assign issue     = I_Enable & ~I_Empty & slot_free & (state != ST_IDLE);
  assign body_end  = (state == ST_LOOP) && (body_idx == body_len - AW'(1));

  // The rewind rides on the read of the last body entry, so it never appears alone.
  assign O_Re     = issue;
  assign O_Update = issue & body_end & (iter_left != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      body_len    <= '0;
      body_idx    <= '0;
      iter_left   <= '0;
      O_UpdateLen <= '0;
      O_LoopAck   <= 1'b0;
      O_LoopDone  <= 1'b0;
      O_Busy      <= 1'b0;
      O_Valid     <= 1'b0;
      O_Data      <= '0;
    end else begin
      O_LoopAck  <= 1'b0;
      O_LoopDone <= 1'b0;

      if (issue) begin
        O_Data  <= I_RData;
        O_Valid <= 1'b1;
      end else if (I_Ready) begin
        O_Valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (I_Enable) state <= ST_RUN;
        end
        ST_RUN: begin
          if (I_LoopReq) begin
            O_LoopAck <= 1'b1;
            if (I_LoopLen == '0 || I_LoopCnt == '0) begin
              O_LoopDone <= 1'b1;
            end else begin
              state       <= ST_LOOP;
              O_Busy      <= 1'b1;
              // Controller loads UpdateLen+1, so S-1 (AW-bit wrap) lands back on S.
              O_UpdateLen <= I_RAddr - AW'(1);
              body_len    <= I_LoopLen;
              iter_left   <= I_LoopCnt - CNT_W'(1);
              body_idx    <= '0;
            end
          end
        end
        ST_LOOP: begin
          if (issue) begin
            if (body_end) begin
              body_idx <= '0;
              if (iter_left != '0) begin
                iter_left <= iter_left - CNT_W'(1);
              end else begin
                state      <= ST_RUN;
                O_Busy     <= 1'b0;
                O_LoopDone <= 1'b1;
              end
            end else begin
              body_idx <= body_idx + AW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ring_buff_loop_reader.sv
// ============================================================================
// Module   : tb_ring_buff_loop_reader
// Function : Directed self-checking bench for ring_buff_loop_reader
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ring_buff_loop_reader;

  localparam int NUM_ENTRY = 16;
  localparam int DATA_W    = 32;
  localparam int CNT_W     = 8;
  localparam int AW        = 4;

  logic              clock;
  logic              reset;
  logic              I_Enable;
  logic              I_Empty;
  logic [AW-1:0]     I_RAddr;
  logic [DATA_W-1:0] I_RData;
  logic              O_Re;
  logic              O_Update;
  logic [AW-1:0]     O_UpdateLen;
  logic              I_LoopReq;
  logic [AW-1:0]     I_LoopLen;
  logic [CNT_W-1:0]  I_LoopCnt;
  logic              O_LoopAck;
  logic              O_LoopDone;
  logic              O_Busy;
  logic              O_Valid;
  logic [DATA_W-1:0] O_Data;
  logic              I_Ready;

  ring_buff_loop_reader #(
    .NUM_ENTRY (NUM_ENTRY),
    .DATA_W    (DATA_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .I_Enable    (I_Enable),
    .I_Empty     (I_Empty),
    .I_RAddr     (I_RAddr),
    .I_RData     (I_RData),
    .O_Re        (O_Re),
    .O_Update    (O_Update),
    .O_UpdateLen (O_UpdateLen),
    .I_LoopReq   (I_LoopReq),
    .I_LoopLen   (I_LoopLen),
    .I_LoopCnt   (I_LoopCnt),
    .O_LoopAck   (O_LoopAck),
    .O_LoopDone  (O_LoopDone),
    .O_Busy      (O_Busy),
    .O_Valid     (O_Valid),
    .O_Data      (O_Data),
    .I_Ready     (I_Ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Controller stand-in: read pointer plus a storage array whose contents encode the address.
  logic [AW-1:0] rptr;
  logic          ld;
  logic [AW-1:0] ld_val;

  always @(posedge clock) begin
    if (ld)          rptr <= ld_val;
    else if (reset)  rptr <= '0;
    else if (O_Re)   rptr <= O_Update ? O_UpdateLen + AW'(1) : rptr + AW'(1);
  end

  function automatic logic [31:0] data_of(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  assign I_RAddr = rptr;
  assign I_RData = data_of(int'(rptr));

  // Negedge monitor: records reads, deliveries, pulses and protocol violations.
  int          rd_q[$];
  int          lp_q[$];
  int          up_q[$];
  logic [31:0] out_q[$];
  int cyc, ack_cnt, done_cnt, upd_cnt, busy_cnt, ack_cyc, done_cyc, last_lp_cyc;
  int viol_empty, viol_upd, viol_full, viol_hold;
  logic        prev_stall;
  logic [31:0] prev_data;

  always @(negedge clock) begin
    if (reset) begin
      rd_q.delete(); lp_q.delete(); up_q.delete(); out_q.delete();
      cyc <= 0; ack_cnt <= 0; done_cnt <= 0; upd_cnt <= 0; busy_cnt <= 0;
      ack_cyc <= 0; done_cyc <= 0; last_lp_cyc <= 0;
      viol_empty <= 0; viol_upd <= 0; viol_full <= 0; viol_hold <= 0;
      prev_stall <= 1'b0; prev_data <= '0;
    end else begin
      cyc <= cyc + 1;
      if (O_Re) begin
        rd_q.push_back(int'(I_RAddr));
        if (O_Busy) begin
          lp_q.push_back(int'(I_RAddr));
          up_q.push_back(O_Update ? NUM_ENTRY + int'(O_UpdateLen) : 0);
          last_lp_cyc <= cyc;
        end
      end
      if (O_Update) upd_cnt <= upd_cnt + 1;
      if (O_Update && !O_Re) viol_upd <= viol_upd + 1;
      if (O_Re && I_Empty) viol_empty <= viol_empty + 1;
      if (O_Re && O_Valid && !I_Ready) viol_full <= viol_full + 1;
      if (O_Valid && I_Ready) out_q.push_back(O_Data);
      if (prev_stall && (!O_Valid || O_Data != prev_data)) viol_hold <= viol_hold + 1;
      prev_stall <= O_Valid & ~I_Ready;
      prev_data  <= O_Data;
      if (O_LoopAck)  begin ack_cnt  <= ack_cnt + 1;  ack_cyc  <= cyc; end
      if (O_LoopDone) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
      if (O_Busy) busy_cnt <= busy_cnt + 1;
    end
  end

  int n_chk;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int p);
    I_Enable = 1'b0; I_Ready = 1'b1; I_Empty = 1'b0;
    I_LoopReq = 1'b0; I_LoopLen = '0; I_LoopCnt = '0;
    reset = 1'b1; ld = 1'b1; ld_val = AW'(p);
    step();
    step();
    reset = 1'b0; ld = 1'b0;
  endtask

  // Reset with pointer at s, enter RUN, request a loop with reads held off, then stream until done.
  task automatic run_loop(input int s, input int len, input int cnt, input int gap, input bit extra_req);
    do_reset(s);
    I_Enable = 1'b1;
    step();
    I_Enable = 1'b0; I_LoopReq = 1'b1; I_LoopLen = AW'(len); I_LoopCnt = CNT_W'(cnt);
    step();
    I_LoopReq = 1'b0; I_Enable = 1'b1;
    for (int i = 0; i < 200 && done_cnt == 0; i++) begin
      step();
      I_Empty   = (i < gap);
      I_LoopReq = extra_req && (i == 1);
    end
    I_Empty = 1'b0; I_LoopReq = 1'b0; I_Enable = 1'b0;
    step();
    step();
  endtask

  int e_addr[$];
  int e_upd[$];

  task automatic check_loop(input string tag);
    check({tag, "_nreads"}, 32'(lp_q.size()), 32'(e_addr.size()));
    foreach (e_addr[i]) begin
      check({tag, "_addr"}, (i < lp_q.size()) ? 32'(lp_q[i]) : 32'hDEAD, 32'(e_addr[i]));
      check({tag, "_upd"},  (i < up_q.size()) ? 32'(up_q[i]) : 32'hDEAD, 32'(e_upd[i]));
    end
    check({tag, "_done_cnt"}, 32'(done_cnt), 1);
    check({tag, "_ack_cnt"}, 32'(ack_cnt), 1);
    check({tag, "_done_lat"}, 32'(done_cyc - last_lp_cyc), 1);
    check({tag, "_busy_span"}, 32'(busy_cnt), 32'(done_cyc - ack_cyc));
    check({tag, "_upd_alone"}, 32'(viol_upd), 0);
  endtask

  initial begin
    logic [19:0] rdy_pat;
    n_chk = 0; n_fail = 0;
    reset = 1'b1; ld = 1'b0; ld_val = '0;
    I_Enable = 1'b0; I_Ready = 1'b1; I_Empty = 1'b0;
    I_LoopReq = 1'b0; I_LoopLen = '0; I_LoopCnt = '0;

    // Reset values, then IDLE->RUN and 1-cycle read latency
    do_reset(0);
    @(negedge clock);
    check("rst_valid", 32'(O_Valid), 0);
    check("rst_re", 32'(O_Re), 0);
    check("rst_busy", 32'(O_Busy), 0);
    check("rst_data", O_Data, 0);
    check("rst_updlen", 32'(O_UpdateLen), 0);
    check("rst_ack_done", 32'({O_LoopAck, O_LoopDone, O_Update}), 0);
    step();
    I_Enable = 1'b1;
    @(negedge clock);
    check("idle_no_re", 32'(O_Re), 0);
    step();
    @(negedge clock);
    check("run_re", 32'(O_Re), 1);
    check("run_addr", 32'(I_RAddr), 0);
    step();
    @(negedge clock);
    check("first_valid", 32'(O_Valid), 1);
    check("first_data", O_Data, data_of(0));

    // Four-entry stream with consumer stalls
    do_reset(0);
    rdy_pat = 20'b1111111111_1001010011;
    for (int c = 0; c < 20; c++) begin
      I_Enable = (rd_q.size() < 4);
      I_Ready  = rdy_pat[c];
      step();
    end
    check("str_nreads", 32'(rd_q.size()), 4);
    check("str_nout", 32'(out_q.size()), 4);
    for (int i = 0; i < 4; i++)
      check("str_data", (i < out_q.size()) ? out_q[i] : 32'hDEAD, data_of(i));
    check("str_re_when_full", 32'(viol_full), 0);
    check("str_hold", 32'(viol_hold), 0);

    // S=5 LEN=3 CNT=2, with an extra request mid-loop that must be ignored
    run_loop(5, 3, 2, 0, 1'b1);
    e_addr = {5, 6, 7, 5, 6, 7};
    e_upd  = {0, 0, 20, 0, 0, 0};
    check_loop("loop5");
    check("loop5_busy_len", 32'(busy_cnt), 6);

    // Wrap: S=14 LEN=4 CNT=2
    run_loop(14, 4, 2, 0, 1'b0);
    e_addr = {14, 15, 0, 1, 14, 15, 0, 1};
    e_upd  = {0, 0, 0, 29, 0, 0, 0, 0};
    check_loop("wrap14");

    // S=0 rewinds with UpdateLen=15
    run_loop(0, 1, 2, 0, 1'b0);
    e_addr = {0, 0};
    e_upd  = {31, 0};
    check_loop("s0");

    // Empty gap of 3 cycles mid-body
    run_loop(3, 2, 3, 3, 1'b0);
    e_addr = {3, 4, 3, 4, 3, 4};
    e_upd  = {0, 18, 0, 18, 0, 0};
    check_loop("gap");
    check("gap_upd_cnt", 32'(upd_cnt), 2);
    check("gap_re_when_empty", 32'(viol_empty), 0);

    // Degenerate requests: CNT=0 then LEN=0
    do_reset(2);
    I_Enable = 1'b1;
    step();
    I_Enable = 1'b0; I_LoopReq = 1'b1; I_LoopLen = AW'(3); I_LoopCnt = '0;
    step();
    I_LoopReq = 1'b0;
    step();
    I_LoopReq = 1'b1; I_LoopLen = '0; I_LoopCnt = CNT_W'(2);
    step();
    I_LoopReq = 1'b0;
    step();
    step();
    check("degen_ack_cnt", 32'(ack_cnt), 2);
    check("degen_done_cnt", 32'(done_cnt), 2);
    check("degen_same_cycle", 32'(done_cyc - ack_cyc), 0);
    check("degen_no_upd", 32'(upd_cnt), 0);
    check("degen_no_busy", 32'(busy_cnt), 0);

    // Reset mid-loop drops everything
    do_reset(0);
    I_Enable = 1'b1;
    step();
    I_Enable = 1'b0; I_LoopReq = 1'b1; I_LoopLen = AW'(4); I_LoopCnt = CNT_W'(3);
    step();
    I_LoopReq = 1'b0; I_Enable = 1'b1;
    step();
    step();
    @(negedge clock);
    check("mid_busy", 32'(O_Busy), 1);
    check("mid_valid", 32'(O_Valid), 1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    check("mrst_busy", 32'(O_Busy), 0);
    check("mrst_valid", 32'(O_Valid), 0);
    check("mrst_data", O_Data, 0);
    check("mrst_re", 32'(O_Re), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

`default_nettype wire
